// File: rtl/nibble_serial_addsub_if.sv
`default_nettype none
// ============================================================================
// Module  : nibble_serial_addsub_if
// Purpose : operand/result valid-ready bus for the nibble-serial add/sub unit
// Revision: 1.0 - initial release
// ============================================================================
interface nibble_serial_addsub_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    // Producer/consumer side
    modport master (
        output in_valid, op_a, op_b, mode, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, zero
    );

    // Arithmetic unit side
    modport slave (
        input  in_valid, op_a, op_b, mode, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_addsub.sv
`default_nettype none
// ============================================================================
// Module  : nibble_serial_addsub
// Purpose : W-bit add/subtract built from one 4-bit slice, LSB nibble first
// Revision: 1.0 - initial release
// ============================================================================
module nibble_serial_addsub #(
    parameter int NIBBLES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    nibble_serial_addsub_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  result_q;
    logic          carry_out_q;
    logic          overflow_q;
    logic          zero_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [4:0]    nib_sum;
    logic [W-1:0]  result_d;
    logic          overflow_d;

    // One 4-bit slice; the carry between nibbles lives only in carry_q.
    always_comb begin
        a_nib      = a_q[{idx_q, 2'b00} +: 4];
        b_nib      = b_q[{idx_q, 2'b00} +: 4];
        nib_sum    = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        result_d   = result_q;
        result_d[{idx_q, 2'b00} +: 4] = nib_sum[3:0];
        overflow_d = (a_q[W-1] == b_q[W-1]) && (result_d[W-1] != a_q[W-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        // Subtract is A + ~B + 1: invert B once, seed carry with mode.
                        a_q        <= bus.op_a;
                        b_q        <= bus.mode ? ~bus.op_b : bus.op_b;
                        carry_q    <= bus.mode;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q <= result_d;
                    carry_q  <= nib_sum[4];
                    if (idx_q == LAST_IDX) begin
                        idx_q       <= '0;
                        carry_out_q <= nib_sum[4];
                        overflow_q  <= overflow_d;
                        zero_q      <= (result_d == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
endmodule
`default_nettype wire

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle add/subtract sequencer that builds a WIDTH-bit add/sub from one 4-bit add/sub slice with carry-in, one nibble per clock, LSB nibble first.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
- Flag semantics match the team's 4-bit adder-subtractor:
  - mode 1 computes A + ~B + 1.
  - carry_out = 1 means no borrow on subtract.
  - overflow is signed two's-complement overflow.

Parameters:
- NIBBLES, 4, number of 4-bit slices. Operand width W = 4*NIBBLES. Legal range 2..16.

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, producer offers operands.
- in_ready, output, 1, block can accept operands.
- op_a, input, W, operand A.
- op_b, input, W, operand B.
- mode, input, 1, 0 = add, 1 = subtract.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts the result.
- result, output, W, sum or difference, modulo 2^W.
- carry_out, output, 1, carry out of the MSB nibble (borrow = ~carry_out).
- overflow, output, 1, signed overflow of the full W-bit operation.
- zero, output, 1, result == 0.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - in_ready = 1, out_valid = 0.
  - result, carry_out, overflow, zero = 0.
  - Internal operand registers, nibble index and carry are cleared.
  - Reset is effective immediately, including mid-RUN or in DONE; the partial result is discarded and nothing is output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready at an edge: latch op_a, op_b, mode; set the B operand to mode ? ~op_b : op_b; set carry = mode; idx = 0; go to RUN.
  - Operand inputs are don't-care outside the accept edge.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge computes {c, s} = A[idx] + Bop[idx] + carry, where A[idx] and Bop[idx] are 4-bit nibbles.
  - s is written into result nibble idx, carry <= c, idx <= idx + 1.
  - On the edge processing idx = NIBBLES-1, go to DONE and register the flags:
    - carry_out = c.
    - overflow = (A[W-1] == Bop[W-1]) && (result[W-1] != A[W-1]), evaluated on the final MSB.
    - zero = (full result == 0).
- DONE:
  - out_valid = 1; result and flags are held stable while out_ready = 0 (backpressure of unlimited length).
  - On out_valid & out_ready: go to IDLE, out_valid falls on the next cycle.
  - in_ready stays 0 in DONE, so there is no same-edge accept. The next accept is possible at the first edge after the return to IDLE.
  - result and flags keep their last values in IDLE until overwritten. result nibbles are overwritten progressively during the next RUN.
- Latency:
  - The accept edge is edge 0.
  - out_valid is high after edge NIBBLES (NIBBLES clocks of RUN).
  - Throughput is one operation per NIBBLES+2 cycles with out_ready held high.
- Width rules:
  - Internal nibble sum is 5 bits; carry chains only through the carry register.
  - Operation is modulo 2^W; no saturation.
  - idx width = clog2(NIBBLES); idx never exceeds NIBBLES-1.
- in_valid asserted during RUN/DONE is ignored; the producer must hold it until in_ready.
- out_ready asserted outside DONE has no effect.

Test Plan:
- NIBBLES=4, add 0x1234 + 0x0FFF (mode 0) → result 0x2233, carry_out 0, overflow 0, zero 0. out_valid rises exactly 4 clocks after the accept edge.
- Subtract 0x0005 − 0x0007 → result 0xFFFE, carry_out 0 (borrow), overflow 0, zero 0. Subtract 0x1234 − 0x1234 → 0x0000, carry_out 1, zero 1.
- Overflow cases:
  - Add 0x7FFF + 0x0001 → 0x8000, overflow 1, carry_out 0.
  - Subtract 0x8000 − 0x0001 → 0x7FFF, overflow 1, carry_out 1.
  - Add 0xFFFF + 0x0001 → 0x0000, carry_out 1, overflow 0, zero 1.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → result and flags stable, in_ready = 0, new in_valid ignored. Release → IDLE next cycle, the next operation is accepted and computed correctly.
- Reset mid-RUN: drop rst_n after 2 nibbles of 0x1234 + 0x0FFF → all outputs 0 immediately, in_ready = 1 after release. The next operation 0x0001 + 0x0001 → 0x0002 with no residue from the aborted operation.
- Back-to-back with in_valid and out_ready tied high: three operations complete at 6-cycle spacing with correct results. Also repeat the add/sub cases with NIBBLES=2 (for example 0x7F + 0x01 → 0x80, overflow 1).
